// File: rtl/board_print_pkg.sv
// ============================================================================
// Module      : board_print_pkg
// Description : Shared ASCII constants, printer state encoding and the
//               per-print byte-count helper for board_uart_printer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package board_print_pkg;

    localparam logic [7:0] c_SPACE = 8'h20;
    localparam logic [7:0] c_DOT   = 8'h2E;
    localparam logic [7:0] c_HASH  = 8'h23;
    localparam logic [7:0] c_PIPE  = 8'h7C;
    localparam logic [7:0] c_CR    = 8'h0D;
    localparam logic [7:0] c_LF    = 8'h0A;
    localparam logic [7:0] c_ZERO  = 8'h30;
    localparam logic [7:0] c_S     = 8'h53;
    localparam logic [7:0] c_COLON = 8'h3A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_CELL   = 3'd2,
        ST_SEP    = 3'd3,
        ST_EOL_CR = 3'd4,
        ST_EOL_LF = 3'd5,
        ST_SCORE  = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    // Bytes emitted by one print: N rows of cells, separators and CR LF,
    // plus "S:" + digits + CR LF when the score line is enabled.
    function automatic int print_byte_count(input int n, input int cell_chars,
                                            input int score_digits, input bit score_en);
        int total;
        total = n * (n * cell_chars + n - 1 + 2);
        if (score_en) begin
            total = total + score_digits + 4;
        end
        return total;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exp_to_bcd.sv
// ============================================================================
// Module      : exp_to_bcd
// Description : Combinational map of a tile exponent e to the five BCD
//               digits of 2^e and the number of significant digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_to_bcd #(
    parameter int TILE_W = 4
) (
    input  logic [TILE_W-1:0] tile_exp,
    output logic [19:0]       bcd,
    output logic [2:0]        num_digits
);

    logic [3:0] w_exp;

    always_comb begin
        w_exp      = 4'(tile_exp);
        bcd        = 20'h00001;
        num_digits = 3'd1;
        case (w_exp)
            4'd0:  begin bcd = 20'h00001; num_digits = 3'd1; end
            4'd1:  begin bcd = 20'h00002; num_digits = 3'd1; end
            4'd2:  begin bcd = 20'h00004; num_digits = 3'd1; end
            4'd3:  begin bcd = 20'h00008; num_digits = 3'd1; end
            4'd4:  begin bcd = 20'h00016; num_digits = 3'd2; end
            4'd5:  begin bcd = 20'h00032; num_digits = 3'd2; end
            4'd6:  begin bcd = 20'h00064; num_digits = 3'd2; end
            4'd7:  begin bcd = 20'h00128; num_digits = 3'd3; end
            4'd8:  begin bcd = 20'h00256; num_digits = 3'd3; end
            4'd9:  begin bcd = 20'h00512; num_digits = 3'd3; end
            4'd10: begin bcd = 20'h01024; num_digits = 3'd4; end
            4'd11: begin bcd = 20'h02048; num_digits = 3'd4; end
            4'd12: begin bcd = 20'h04096; num_digits = 3'd4; end
            4'd13: begin bcd = 20'h08192; num_digits = 3'd4; end
            4'd14: begin bcd = 20'h16384; num_digits = 3'd5; end
            4'd15: begin bcd = 20'h32768; num_digits = 3'd5; end
            default: begin bcd = 20'h00001; num_digits = 3'd1; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/board_uart_printer.sv
// ============================================================================
// Module      : board_uart_printer
// Description : Snapshots an N x N board (and score) on start and streams it
//               as fixed-width ASCII over a valid/ready byte handshake.
//               Define BOARD_PRINT_SCORE_EN to add the "S:nnnnnnn" line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_uart_printer
    import board_print_pkg::*;
#(
    parameter int N            = 4,
    parameter int TILE_W       = 4,
    parameter int CELL_CHARS   = 5,
    parameter int SCORE_W      = 21,
    parameter int SCORE_DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N*N*TILE_W-1:0] board,
    input  logic [SCORE_W-1:0]    score,
    output logic [7:0]            char_out,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int c_RC_W    = (N > 1) ? $clog2(N) : 1;
    localparam int c_CHR_MAX = (CELL_CHARS > SCORE_DIGITS + 3) ? CELL_CHARS : SCORE_DIGITS + 3;
    localparam int c_CHR_W   = $clog2(c_CHR_MAX + 1);

`ifdef BOARD_PRINT_SCORE_EN
    localparam state_t c_FIRST_STATE     = ST_CONV;
    localparam state_t c_ROWS_DONE_STATE = ST_SCORE;
    localparam int     c_DD_W            = $clog2(SCORE_W + 1);
    localparam int     c_BCD_W           = 4 * SCORE_DIGITS;
`else
    localparam state_t c_FIRST_STATE     = ST_CELL;
    localparam state_t c_ROWS_DONE_STATE = ST_DONE;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [N*N*TILE_W-1:0]   r_board;
    logic [c_RC_W-1:0]       r_row;
    logic [c_RC_W-1:0]       r_col;
    logic [c_CHR_W-1:0]      r_chr;
    logic [7:0]              r_char_out;
    logic                    r_char_valid;

    logic                    w_xfer;
    logic                    w_emit;
    logic                    w_accept;
    logic                    w_cell_last;
    logic                    w_col_last;
    logic                    w_row_last;
    logic                    w_score_last;
    logic                    w_conv_last;
    int                      w_tile_idx;
    int                      w_pos_r;
    logic [TILE_W-1:0]       w_tile;
    logic [19:0]             w_bcd;
    logic [2:0]              w_num_digits;
    logic [7:0]              w_byte;

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_xfer       = r_char_valid && char_ready;
    assign w_emit       = (r_state == ST_CELL) || (r_state == ST_SEP) || (r_state == ST_EOL_CR) ||
                          (r_state == ST_EOL_LF) || (r_state == ST_SCORE);
    assign w_cell_last  = (r_chr == c_CHR_W'(CELL_CHARS - 1));
    assign w_score_last = (r_chr == c_CHR_W'(SCORE_DIGITS + 3));
    assign w_col_last   = (r_col == c_RC_W'(N - 1));
    assign w_row_last   = (r_row == c_RC_W'(N - 1));

`ifdef BOARD_PRINT_SCORE_EN
    // Sequential double-dabble: one add-3/shift step per cycle in CONV.
    logic [SCORE_W-1:0]  r_dd_bin;
    logic [c_BCD_W-1:0]  r_dd_bcd;
    logic [c_DD_W-1:0]   r_dd_cnt;
    logic [c_BCD_W-1:0]  w_dd_adj;
    logic [c_BCD_W-1:0]  w_dd_next;
    logic                w_dd_unused_msb;

    always_comb begin
        w_dd_adj = r_dd_bcd;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (r_dd_bcd[d*4 +: 4] >= 4'd5) begin
                w_dd_adj[d*4 +: 4] = r_dd_bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Digits above SCORE_DIGITS fall off the top, leaving the low digits.
    assign {w_dd_unused_msb, w_dd_next} = {w_dd_adj, r_dd_bin[SCORE_W-1]};
    assign w_conv_last = (r_dd_cnt == c_DD_W'(SCORE_W - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dd_bin <= '0;
            r_dd_bcd <= '0;
            r_dd_cnt <= '0;
        end else if (w_accept) begin
            r_dd_bin <= score;
            r_dd_bcd <= '0;
            r_dd_cnt <= '0;
        end else if (r_state == ST_CONV) begin
            r_dd_bin <= {r_dd_bin[SCORE_W-2:0], 1'b0};
            r_dd_bcd <= w_dd_next;
            r_dd_cnt <= r_dd_cnt + 1'b1;
        end
    end
`else
    logic w_score_unused;

    assign w_score_unused = ^score;
    assign w_conv_last    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = c_FIRST_STATE;
            ST_CONV:   if (w_conv_last) w_state_nxt = ST_CELL;
            ST_CELL:   if (w_xfer && w_cell_last) w_state_nxt = w_col_last ? ST_EOL_CR : ST_SEP;
            ST_SEP:    if (w_xfer) w_state_nxt = ST_CELL;
            ST_EOL_CR: if (w_xfer) w_state_nxt = ST_EOL_LF;
            ST_EOL_LF: if (w_xfer) w_state_nxt = w_row_last ? c_ROWS_DONE_STATE : ST_CELL;
            ST_SCORE:  if (w_xfer && w_score_last) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Board snapshot is pure datapath; it is only read while busy.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_board <= board;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
            r_chr <= '0;
        end else if (w_accept) begin
            r_row <= '0;
            r_col <= '0;
            r_chr <= '0;
        end else if (w_xfer) begin
            case (r_state)
                ST_CELL:   r_chr <= w_cell_last ? '0 : r_chr + 1'b1;
                ST_SEP:    r_col <= r_col + 1'b1;
                ST_EOL_LF: begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end
                ST_SCORE:  r_chr <= r_chr + 1'b1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_tile_idx = int'(r_row) * N + int'(r_col);
        w_tile     = r_board[w_tile_idx*TILE_W +: TILE_W];
    end

    exp_to_bcd #(
        .TILE_W     (TILE_W)
    ) u_exp_to_bcd (
        .tile_exp   (w_tile),
        .bcd        (w_bcd),
        .num_digits (w_num_digits)
    );

    always_comb begin
        w_byte  = c_SPACE;
        w_pos_r = CELL_CHARS - 1 - int'(r_chr);
        case (r_state)
            ST_CELL: begin
                if (w_tile == '0) begin
                    w_byte = (w_pos_r == 0) ? c_DOT : c_SPACE;
                end else if (int'(w_num_digits) > CELL_CHARS) begin
                    w_byte = c_HASH;
                end else if (w_pos_r < int'(w_num_digits)) begin
                    w_byte = c_ZERO + {4'd0, w_bcd[w_pos_r*4 +: 4]};
                end
            end
            ST_SEP:    w_byte = c_PIPE;
            ST_EOL_CR: w_byte = c_CR;
            ST_EOL_LF: w_byte = c_LF;
            ST_SCORE: begin
                if (r_chr == '0) begin
                    w_byte = c_S;
                end else if (int'(r_chr) == 1) begin
                    w_byte = c_COLON;
                end else if (int'(r_chr) <= SCORE_DIGITS + 1) begin
`ifdef BOARD_PRINT_SCORE_EN
                    w_byte = c_ZERO + {4'd0, r_dd_bcd[(SCORE_DIGITS + 1 - int'(r_chr))*4 +: 4]};
`else
                    w_byte = c_ZERO;
`endif
                end else if (int'(r_chr) == SCORE_DIGITS + 2) begin
                    w_byte = c_CR;
                end else begin
                    w_byte = c_LF;
                end
            end
            default:   w_byte = c_SPACE;
        endcase
    end

    // A byte is loaded on a cycle with nothing pending, so transfers are
    // separated by at least one idle cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_char_out   <= 8'h00;
            r_char_valid <= 1'b0;
        end else if (w_xfer) begin
            r_char_valid <= 1'b0;
        end else if (w_emit && !r_char_valid) begin
            r_char_out   <= w_byte;
            r_char_valid <= 1'b1;
        end
    end

    assign char_out   = r_char_out;
    assign char_valid = r_char_valid;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_board_uart_printer.sv
// ============================================================================
// Module      : tb_board_uart_printer
// Description : Scoreboard bench for board_uart_printer (default geometry plus
//               a CELL_CHARS=4 instance); honours BOARD_PRINT_SCORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_uart_printer;
    import board_print_pkg::*;

    localparam int N            = 4;
    localparam int TILE_W       = 4;
    localparam int SCORE_W      = 21;
    localparam int SCORE_DIGITS = 7;
`ifdef BOARD_PRINT_SCORE_EN
    localparam int c_EXP_BYTES  = 111;
    localparam int c_EXP_BYTES4 = 95;
    localparam bit c_SCORE_EN   = 1'b1;
`else
    localparam int c_EXP_BYTES  = 100;
    localparam int c_EXP_BYTES4 = 84;
    localparam bit c_SCORE_EN   = 1'b0;
`endif

    logic                  clk    = 1'b0;
    logic                  rst    = 1'b0;
    logic                  start  = 1'b0;
    logic                  start4 = 1'b0;
    logic                  ready  = 1'b1;
    logic [N*N*TILE_W-1:0] board  = '0;
    logic [SCORE_W-1:0]    score  = '0;
    logic [7:0]            char_out, char_out4;
    logic                  char_valid, valid4, busy, busy4, done, done4;

    int         checks    = 0;
    int         failures  = 0;
    int         xfer_cnt  = 0;
    int         xfer4_cnt = 0;
    logic [7:0] q[$];
    logic [7:0] q4[$];
    logic       hold_vld  = 1'b0;
    logic [7:0] hold_byte = 8'h00;

    always #5 clk = ~clk;

    board_uart_printer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board      (board),
        .score      (score),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (ready),
        .busy       (busy),
        .done       (done)
    );

    board_uart_printer #(.CELL_CHARS(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .board      (board),
        .score      (score),
        .char_out   (char_out4),
        .char_valid (valid4),
        .char_ready (1'b1),
        .busy       (busy4),
        .done       (done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid && ready here.
    always @(negedge clk) begin
        if (rst && char_valid) begin
            if (hold_vld) check("hold_stable", {24'd0, char_out}, {24'd0, hold_byte});
            if (ready) begin
                xfer_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte actual=%0h required=none at %0t", char_out, $time);
                end else begin
                    check("byte", {24'd0, char_out}, {24'd0, q.pop_front()});
                end
                hold_vld <= 1'b0;
            end else begin
                hold_vld  <= 1'b1;
                hold_byte <= char_out;
            end
        end else begin
            hold_vld <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst && valid4) begin
            xfer4_cnt++;
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_byte4 actual=%0h required=none at %0t", char_out4, $time);
            end else begin
                check("byte4", {24'd0, char_out4}, {24'd0, q4.pop_front()});
            end
        end
    end

    task automatic push_str(input string s, input bit to4);
        for (int i = 0; i < s.len(); i++) begin
            if (to4) q4.push_back(s[i]);
            else     q.push_back(s[i]);
        end
    endtask

    task automatic push_score(input string s, input bit to4);
`ifdef BOARD_PRINT_SCORE_EN
        push_str(s, to4);
`else
        if (s.len() == 0) push_str("", to4);
`endif
    endtask

    task automatic set_row(input int r, input int e0, input int e1, input int e2, input int e3);
        board[(r*N+0)*TILE_W +: TILE_W] = 4'(e0);
        board[(r*N+1)*TILE_W +: TILE_W] = 4'(e1);
        board[(r*N+2)*TILE_W +: TILE_W] = 4'(e2);
        board[(r*N+3)*TILE_W +: TILE_W] = 4'(e3);
    endtask

    task automatic load_b();
        set_row(0, 1, 11, 15, 0);
        set_row(1, 2, 3, 4, 5);
        set_row(2, 6, 7, 8, 9);
        set_row(3, 10, 12, 13, 14);
    endtask

    task automatic push_empty_rows();
        for (int r = 0; r < N; r++) push_str("    .|    .|    .|    .\r\n", 1'b0);
    endtask

    task automatic push_b_rows();
        push_str("    2| 2048|32768|    .\r\n", 1'b0);
        push_str("    4|    8|   16|   32\r\n", 1'b0);
        push_str("   64|  128|  256|  512\r\n", 1'b0);
        push_str(" 1024| 4096| 8192|16384\r\n", 1'b0);
    endtask

    task automatic run_print(input bit bp, input bit disturb, input int exp_bytes);
        int budget, cyc, busy_bad, extra_done;
        bit seen;
        budget     = 6 * print_byte_count(N, 5, SCORE_DIGITS, c_SCORE_EN) + 100;
        xfer_cnt   = 0;
        cyc        = 0;
        busy_bad   = 0;
        extra_done = 0;
        seen       = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            if (bp) ready = 1'($urandom_range(0, 1));
            if (disturb && cyc == 60) begin
                board = ~board;
                score = ~score;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            cyc++;
        end
        check("print_done_seen", {31'd0, seen}, 32'd1);
        check("busy_window", busy_bad, 0);
        @(posedge clk); #1 ready = 1'b1;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("done_single", extra_done, 0);
        check("byte_count", xfer_cnt, exp_bytes);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc;
        int idle_hits;
        rst   = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_char_out", {24'd0, char_out}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Empty board, zero score, free-running sink.
        board = '0;
        score = '0;
        push_empty_rows();
        push_score("S:0000000\r\n", 1'b0);
        run_print(1'b0, 1'b0, c_EXP_BYTES);

        // Directed tile values incl. 2, 2048, 32768 and empty.
        load_b();
        score = 21'd12345;
        push_b_rows();
        push_score("S:0012345\r\n", 1'b0);
        run_print(1'b0, 1'b0, c_EXP_BYTES);

        // Same stream under random back-pressure.
        push_b_rows();
        push_score("S:0012345\r\n", 1'b0);
        run_print(1'b1, 1'b0, c_EXP_BYTES);

        // Inputs change and start re-pulses mid-print; snapshot must hold.
        load_b();
        score = 21'd12345;
        push_b_rows();
        push_score("S:0012345\r\n", 1'b0);
        run_print(1'b0, 1'b1, c_EXP_BYTES);
        idle_hits = 0;
        repeat (300) begin
            @(negedge clk);
            if (char_valid || busy) idle_hits++;
        end
        check("no_second_print", idle_hits, 0);

        // Maximum score value.
        board = '0;
        score = 21'd2097151;
        push_empty_rows();
        push_score("S:2097151\r\n", 1'b0);
        run_print(1'b0, 1'b0, c_EXP_BYTES);

        // Reset while a byte is pending, then a fresh print from row 0.
        load_b();
        score = 21'd12345;
        push_b_rows();
        push_score("S:0012345\r\n", 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 ready = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (char_valid) break;
            cyc++;
        end
        check("pending_before_rst", {31'd0, char_valid}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_char_valid", {31'd0, char_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        ready = 1'b1;
        q.delete();
        push_b_rows();
        push_score("S:0012345\r\n", 1'b0);
        run_print(1'b0, 1'b0, c_EXP_BYTES);

        // Four-character cells: 16384 and 32768 overflow to '#'.
        load_b();
        score = 21'd12345;
        push_str("   2|2048|####|   .\r\n", 1'b1);
        push_str("   4|   8|  16|  32\r\n", 1'b1);
        push_str("  64| 128| 256| 512\r\n", 1'b1);
        push_str("1024|4096|8192|####\r\n", 1'b1);
        push_score("S:0012345\r\n", 1'b1);
        xfer4_cnt = 0;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            if (done4) break;
            cyc++;
        end
        check("dut4_done", {31'd0, done4}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("dut4_byte_count", xfer4_cnt, c_EXP_BYTES4);
        check("dut4_queue_drained", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
